fpu_mul_initiator: RTL and testbench

//  Initiator for the fpnew FP16 MUL handshake interface; the requester end of the FPU port.

---
 rtl/fpu_init_pkg.sv | 31 +++
 rtl/fpu_res_fifo.sv | 54 +++++
 rtl/fpu_mul_initiator.sv | 189 ++++++++++++++++++
 tb/tb_fpu_mul_initiator.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_init_pkg.sv
// Shared types and helpers for the fpnew FP16 multiply initiator and its result FIFO.
package fpu_init_pkg;

    localparam int FP_WIDTH = 16;
    localparam int STATUS_W = 5;

    // Bit order matches the fpnew status vector {NV,DZ,OF,UF,NX}
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        status_t               status;
        logic [FP_WIDTH-1:0]   result;
    } res_entry_t;

    typedef enum logic {
        ST_FLUSH,
        ST_RUN
    } flush_state_t;

    // One extra bit so the count can reach MAX_OUTSTANDING itself
    function automatic int credit_w(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit to tell full from empty.
module fpu_res_fifo
    import fpu_init_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = res_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   empty,
    output logic   full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpu_mul_initiator.sv
// Requester end of the fpnew FP16 MUL port: issues tagged operand pairs, collects in-order results.
// Optional statistics ports are populated when FPU_INIT_STATS_EN is defined.
module fpu_mul_initiator
    import fpu_init_pkg::*;
#(
    parameter int WIDTH           = FP_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [2*WIDTH-1:0]   fpu_operands_o,
    output logic [TAG_W-1:0]     fpu_tag_o,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic                 fpu_flush_o,
    input  logic [WIDTH-1:0]     fpu_result_i,
    input  logic [STATUS_W-1:0]  fpu_status_i,
    input  logic [TAG_W-1:0]     fpu_tag_i,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    output logic [WIDTH-1:0]     res_o,
    output logic [STATUS_W-1:0]  res_status_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [TAG_W:0]       outstanding_o,
    output logic                 tag_err_o,
    output logic [STATUS_W-1:0]  stat_flags_o,
    output logic [15:0]          retired_cnt_o
);

    localparam int CNT_W = credit_w(MAX_OUTSTANDING);

    flush_state_t      state_q;
    flush_state_t      state_d;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [TAG_W-1:0]  tag_q;
    logic              valid_q;
    logic [TAG_W-1:0]  issue_tag_q;
    logic [TAG_W-1:0]  exp_tag_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic              tag_err_q;

    logic              accept;
    logic              pop;
    logic              push_req;
    logic              push_take;
    logic              push_drop;
    res_entry_t        push_entry;
    res_entry_t        head_entry;
    logic              fifo_empty;
    logic              fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    // The FPU is held in flush for exactly one edge after reset releases
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_FLUSH;
        endcase
    end

    assign fpu_flush_o     = (state_q == ST_FLUSH);
    assign fpu_out_ready_o = !rst && !fpu_flush_o;

    assign req_ready_o = (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                       && (!valid_q || fpu_in_ready_i)
                       && !fpu_flush_o;
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = res_valid_o && res_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            issue_tag_q <= '0;
        end else if (accept) begin
            a_q         <= a_i;
            b_q         <= b_i;
            tag_q       <= issue_tag_q;
            valid_q     <= 1'b1;
            issue_tag_q <= issue_tag_q + 1'b1;
        end else if (valid_q && fpu_in_ready_i) begin
            valid_q     <= 1'b0;
        end
    end

    assign fpu_operands_o = {b_q, a_q};
    assign fpu_tag_o      = tag_q;
    assign fpu_in_valid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding_o = outstanding_q;

    assign push_req  = fpu_out_valid_i && fpu_out_ready_o;
    assign push_drop = push_req && fifo_full && !pop;
    assign push_take = push_req && !push_drop;

    always_comb begin
        push_entry        = '0;
        push_entry.status = status_t'(fpu_status_i);
        push_entry.result = fpu_result_i;
    end

    // Tag mismatches and credit violations are flagged but never stall the result path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_tag_q <= '0;
            tag_err_q <= 1'b0;
        end else if (push_req) begin
            exp_tag_q <= exp_tag_q + 1'b1;
            if ((fpu_tag_i != exp_tag_q) || push_drop) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign tag_err_o = tag_err_q;

    fpu_res_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .entry_t (res_entry_t)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign res_valid_o  = !fifo_empty;
    assign res_o        = head_entry.result;
    assign res_status_o = head_entry.status;

`ifdef FPU_INIT_STATS_EN
    logic [STATUS_W-1:0] stat_flags_q;
    logic [15:0]         retired_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flags_q  <= '0;
            retired_cnt_q <= '0;
        end else if (push_take) begin
            stat_flags_q <= stat_flags_q | fpu_status_i;
            if (retired_cnt_q != 16'hFFFF) begin
                retired_cnt_q <= retired_cnt_q + 16'd1;
            end
        end
    end

    assign stat_flags_o  = stat_flags_q;
    assign retired_cnt_o = retired_cnt_q;
`else
    assign stat_flags_o  = '0;
    assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpu_mul_initiator.sv
// Directed self-checking bench for fpu_mul_initiator with a fixed-latency fpnew MUL responder.
module tb_fpu_mul_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] fpu_operands;
    logic [1:0]  fpu_tag;
    logic        fpu_in_valid;
    logic        fpu_in_ready = 1'b1;
    logic        fpu_flush;
    logic [15:0] fpu_result;
    logic [4:0]  fpu_status;
    logic [1:0]  fpu_tag_ret;
    logic        fpu_out_valid;
    logic        fpu_out_ready;
    logic [15:0] res;
    logic [4:0]  res_status;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [2:0]  outstanding;
    logic        tag_err;
    logic [4:0]  stat_flags;
    logic [15:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_mul_initiator dut (
        .clk             (clk),
        .rst             (rst),
        .a_i             (a_in),
        .b_i             (b_in),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .fpu_operands_o  (fpu_operands),
        .fpu_tag_o       (fpu_tag),
        .fpu_in_valid_o  (fpu_in_valid),
        .fpu_in_ready_i  (fpu_in_ready),
        .fpu_flush_o     (fpu_flush),
        .fpu_result_i    (fpu_result),
        .fpu_status_i    (fpu_status),
        .fpu_tag_i       (fpu_tag_ret),
        .fpu_out_valid_i (fpu_out_valid),
        .fpu_out_ready_o (fpu_out_ready),
        .res_o           (res),
        .res_status_o    (res_status),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .outstanding_o   (outstanding),
        .tag_err_o       (tag_err),
        .stat_flags_o    (stat_flags),
        .retired_cnt_o   (retired_cnt)
    );

    // Hand-known FP16 products for the operand pairs used below
    function automatic logic [15:0] ref_res(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h7BFF && b == 16'h7BFF) return 16'h7C00;
        if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
        if (a == 16'h3C00) return b;
        if (b == 16'h3C00) return a;
        return 16'h0000;
    endfunction

    function automatic logic [4:0] ref_st(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h7BFF && b == 16'h7BFF) return 5'b00101;
        return 5'b00000;
    endfunction

    typedef struct {
        logic [1:0]  tag;
        logic [15:0] res;
        logic [4:0]  st;
        int          seq;
        int          due;
    } fpu_op_t;

    fpu_op_t fq[$];
    int      cyc;
    int      seq_cnt;
    int      corrupt_seq = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            cyc           <= 0;
            seq_cnt       <= 0;
            fpu_out_valid <= 1'b0;
            fpu_result    <= '0;
            fpu_status    <= '0;
            fpu_tag_ret   <= '0;
        end else begin
            cyc <= cyc + 1;
            if (fq.size() > 0 && fq[0].due <= cyc) begin
                fpu_out_valid <= 1'b1;
                fpu_result    <= fq[0].res;
                fpu_status    <= fq[0].st;
                fpu_tag_ret   <= (fq[0].seq == corrupt_seq) ? fq[0].tag + 2'd1 : fq[0].tag;
                void'(fq.pop_front());
            end else begin
                fpu_out_valid <= 1'b0;
            end
            if (fpu_in_valid && fpu_in_ready) begin
                fq.push_back(fpu_op_t'{tag: fpu_tag,
                                       res: ref_res(fpu_operands[15:0], fpu_operands[31:16]),
                                       st:  ref_st(fpu_operands[15:0], fpu_operands[31:16]),
                                       seq: seq_cnt,
                                       due: cyc + 2});
                seq_cnt <= seq_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid    = 1'b0;
        res_ready    = 1'b0;
        fpu_in_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b);
        logic ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        a_in      = a;
        b_in      = b;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (req_ready) ok = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput({name, "_accept"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_res(input string name);
        for (int c = 0; c < 30 && !res_valid; c++) @(negedge clk);
        checkOutput({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic pop_result(input string name, input logic [15:0] r, input logic [4:0] st);
        wait_res(name);
        checkOutput({name, "_res"}, {16'd0, res}, {16'd0, r});
        checkOutput({name, "_st"}, {27'd0, res_status}, {27'd0, st});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] vec2 [8];
        logic [1:0]  tag_exp;
        logic        fire;
        int          acc;
        int          popped;

        vec2 = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_flush", {31'd0, fpu_flush}, 32'd1);
        checkOutput("rst_out_ready", {31'd0, fpu_out_ready}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_in_valid", {31'd0, fpu_in_valid}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_outstanding", {29'd0, outstanding}, 32'd0);
        checkOutput("rst_operands", fpu_operands, 32'd0);
        checkOutput("rst_tag_err", {31'd0, tag_err}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_flush_held", {31'd0, fpu_flush}, 32'd1);
        @(negedge clk);
        checkOutput("rel_flush_clear", {31'd0, fpu_flush}, 32'd0);
        checkOutput("rel_out_ready", {31'd0, fpu_out_ready}, 32'd1);
        checkOutput("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Test 1: single 1.0 * 2.0
        applyStimulus("t1", 16'h3C00, 16'h4000);
        checkOutput("t1_in_valid", {31'd0, fpu_in_valid}, 32'd1);
        checkOutput("t1_operands", fpu_operands, 32'h4000_3C00);
        checkOutput("t1_tag", {30'd0, fpu_tag}, 32'd0);
        checkOutput("t1_outstanding", {29'd0, outstanding}, 32'd1);
        pop_result("t1", 16'h4000, 5'b00000);
        checkOutput("t1_outstanding_end", {29'd0, outstanding}, 32'd0);

        // Test 2: eight back-to-back requests against a stalled consumer
        do_reset();
        tag_exp   = 2'd0;
        acc       = 0;
        popped    = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_in = 16'h3C00;
            b_in = vec2[acc];
            fire = req_ready;
            if (fpu_in_valid && fpu_in_ready) begin
                checkOutput("t2_tag", {30'd0, fpu_tag}, {30'd0, tag_exp});
                tag_exp = tag_exp + 2'd1;
            end
            @(negedge clk);
            if (fire) acc++;
        end
        checkOutput("t2_accepted", acc, 4);
        checkOutput("t2_outstanding_full", {29'd0, outstanding}, 32'd4);
        checkOutput("t2_req_ready_full", {31'd0, req_ready}, 32'd0);
        res_ready = 1'b1;
        for (int c = 0; c < 60 && popped < 8; c++) begin
            req_valid = (acc < 8);
            a_in      = 16'h3C00;
            b_in      = vec2[(acc < 8) ? acc : 7];
            fire      = req_valid && req_ready;
            if (fpu_in_valid && fpu_in_ready) begin
                checkOutput("t2_tag", {30'd0, fpu_tag}, {30'd0, tag_exp});
                tag_exp = tag_exp + 2'd1;
            end
            if (res_valid) begin
                checkOutput("t2_res", {16'd0, res}, {16'd0, vec2[popped]});
                popped++;
            end
            @(negedge clk);
            if (fire) acc++;
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        checkOutput("t2_popped", popped, 8);
        checkOutput("t2_outstanding_end", {29'd0, outstanding}, 32'd0);
        checkOutput("t2_tag_err", {31'd0, tag_err}, 32'd0);

        // Test 3: FPU stalls the issue register
        do_reset();
        fpu_in_ready = 1'b0;
        applyStimulus("t3", 16'h3C00, 16'h4400);
        req_valid = 1'b1;
        a_in      = 16'h3C00;
        b_in      = 16'h4800;
        for (int c = 0; c < 3; c++) begin
            checkOutput("t3_in_valid", {31'd0, fpu_in_valid}, 32'd1);
            checkOutput("t3_operands", fpu_operands, 32'h4400_3C00);
            checkOutput("t3_tag", {30'd0, fpu_tag}, 32'd0);
            checkOutput("t3_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("t3_outstanding", {29'd0, outstanding}, 32'd1);
            @(negedge clk);
        end
        req_valid    = 1'b0;
        fpu_in_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_in_valid_drop", {31'd0, fpu_in_valid}, 32'd0);
        pop_result("t3", 16'h4400, 5'b00000);

        // Test 4: FPU returns tag 2 while tag 1 is expected
        do_reset();
        corrupt_seq = 1;
        applyStimulus("t4a", 16'h3C00, 16'h4200);
        pop_result("t4a", 16'h4200, 5'b00000);
        checkOutput("t4_err_before", {31'd0, tag_err}, 32'd0);
        applyStimulus("t4b", 16'h3C00, 16'h4500);
        wait_res("t4b");
        checkOutput("t4_err_set", {31'd0, tag_err}, 32'd1);
        pop_result("t4b", 16'h4500, 5'b00000);
        corrupt_seq = -1;
        applyStimulus("t4c", 16'h3C00, 16'h4600);
        pop_result("t4c", 16'h4600, 5'b00000);
        checkOutput("t4_err_sticky", {31'd0, tag_err}, 32'd1);

        // Test 5: asynchronous reset with two results waiting
        do_reset();
        applyStimulus("t5a", 16'h3C00, 16'h4000);
        applyStimulus("t5b", 16'h3C00, 16'h4200);
        repeat (8) @(negedge clk);
        checkOutput("t5_outstanding", {29'd0, outstanding}, 32'd2);
        checkOutput("t5_res_valid", {31'd0, res_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_outstanding", {29'd0, outstanding}, 32'd0);
        checkOutput("t5_rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("t5_rst_res", {16'd0, res}, 32'd0);
        checkOutput("t5_rst_flush", {31'd0, fpu_flush}, 32'd1);
        checkOutput("t5_rst_out_ready", {31'd0, fpu_out_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t5_flush_held", {31'd0, fpu_flush}, 32'd1);
        @(negedge clk);
        checkOutput("t5_flush_clear", {31'd0, fpu_flush}, 32'd0);
        applyStimulus("t5c", 16'h4000, 16'h4000);
        checkOutput("t5_new_tag", {30'd0, fpu_tag}, 32'd0);
        pop_result("t5c", 16'h4400, 5'b00000);

        // Test 6: overflowing product and statistics
        do_reset();
        applyStimulus("t6", 16'h7BFF, 16'h7BFF);
        pop_result("t6", 16'h7C00, 5'b00101);
`ifdef FPU_INIT_STATS_EN
        checkOutput("t6_stat_flags", {27'd0, stat_flags}, 32'h05);
        checkOutput("t6_retired", {16'd0, retired_cnt}, 32'd1);
`else
        checkOutput("t6_stat_flags_tied", {27'd0, stat_flags}, 32'd0);
        checkOutput("t6_retired_tied", {16'd0, retired_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
